// File: rtl/i2c_oled_responder.sv
// I2C write-only target modelling the SSD1306 side of the bus.
// Decodes address, control bytes (Co, D/C#) and payload bytes into
// command / GDDRAM data strobes, ACKing every accepted byte.
module i2c_oled_responder #(
  parameter logic [6:0] ADDR  = 7'h3C,
  parameter int         CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             cmd_valid,
  output logic [7:0]       cmd_byte,
  output logic             data_valid,
  output logic [7:0]       data_byte,
  output logic             busy,
  output logic [CNT_W-1:0] data_count,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_CTRL, S_CTRL_ACK, S_PAYLOAD, S_PAY_ACK, S_IGNORE
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_h;
  logic        sda_s1, sda_s2, sda_h;
  logic [6:0]  sr;
  logic [2:0]  bitcnt;
  logic        co_latched, dc_latched;

  logic        scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0]  nbyte;

  assign scl_rise = scl_s2 & ~scl_h;
  assign scl_fall = ~scl_s2 & scl_h;
  // sda edges only count as bus conditions while scl is stably high
  assign start_ev = scl_s2 & scl_h & sda_h & ~sda_s2;
  assign stop_ev  = scl_s2 & scl_h & ~sda_h & sda_s2;
  assign nbyte    = {sr, sda_s2};

  // 2-FF synchronizers plus history FF; reset to the idle-bus level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {scl_h, scl_s2, scl_s1} <= 3'b111;
      {sda_h, sda_s2, sda_s1} <= 3'b111;
    end else begin
      {scl_h, scl_s2, scl_s1} <= {scl_s2, scl_s1, scl_in};
      {sda_h, sda_s2, sda_s1} <= {sda_s2, sda_s1, sda_in};
    end
  end

  // protocol FSM with registered outputs; START/STOP override any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sr         <= '0;
      bitcnt     <= '0;
      co_latched <= 1'b0;
      dc_latched <= 1'b0;
      sda_oe     <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      data_valid <= 1'b0;
      data_byte  <= '0;
      busy       <= 1'b0;
      data_count <= '0;
      err        <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      if (start_ev) begin
        state      <= S_ADDR;
        bitcnt     <= '0;
        sr         <= '0;
        data_count <= '0;
        err        <= 1'b0;
        sda_oe     <= 1'b0;
      end else if (stop_ev) begin
        // partial byte is dropped silently
        state  <= S_IDLE;
        bitcnt <= '0;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_CTRL, S_PAYLOAD: begin
            if (scl_rise) begin
              sr     <= nbyte[6:0];
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                if (state == S_ADDR) begin
                  if (nbyte[7:1] == ADDR && !nbyte[0]) begin
                    state <= S_ADDR_ACK;
                    busy  <= 1'b1;
                  end else begin
                    // reads are illegal for this write-only target
                    state <= S_IGNORE;
                    if (nbyte[0]) err <= 1'b1;
                  end
                end else if (state == S_CTRL) begin
                  co_latched <= nbyte[7];
                  dc_latched <= nbyte[6];
                  if (nbyte[5:0] != 6'd0) err <= 1'b1;
                  state <= S_CTRL_ACK;
                end else begin
                  if (dc_latched) begin
                    data_byte  <= nbyte;
                    data_valid <= 1'b1;
                    data_count <= data_count + 1'b1;
                  end else begin
                    cmd_byte  <= nbyte;
                    cmd_valid <= 1'b1;
                  end
                  state <= S_PAY_ACK;
                end
              end
            end
          end
          S_ADDR_ACK, S_CTRL_ACK, S_PAY_ACK: begin
            // first scl fall pulls SDA low, second one releases and moves on
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                if (state == S_ADDR_ACK)      state <= S_CTRL;
                else if (state == S_CTRL_ACK) state <= S_PAYLOAD;
                else if (co_latched)          state <= S_CTRL;
                else                          state <= S_PAYLOAD;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_oled_responder.sv
// Directed bench: bit-bangs an I2C master against the responder and
// checks ACKs, strobes, counters and error flag per scenario.
module tb_i2c_oled_responder;

  localparam int CNT_W = 9;  // 512 bytes wrap data_count back to 0
  localparam int Q     = 3;  // clk cycles per quarter SCL period

  logic             clk = 1'b0;
  logic             rst_n;
  logic             scl;
  logic             sda_drv;
  logic             sda_in;
  logic             sda_oe;
  logic             cmd_valid, data_valid, busy, err;
  logic [7:0]       cmd_byte, data_byte;
  logic [CNT_W-1:0] data_count;

  int vecs = 0;
  int errs = 0;

  logic [7:0] cmd_q[$];
  logic [7:0] data_q[$];
  int         ack_cnt  = 0;
  int         both_cnt = 0;
  logic       oe_d     = 1'b0;

  // open-drain bus: the responder wins when it pulls low
  assign sda_in = sda_drv & ~sda_oe;

  i2c_oled_responder #(.ADDR(7'h3C), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_in),
    .sda_oe(sda_oe), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .data_valid(data_valid), .data_byte(data_byte), .busy(busy),
    .data_count(data_count), .err(err)
  );

  always #5 clk = ~clk;

  // collect strobes and ACK pulses
  always @(negedge clk) begin
    if (cmd_valid)  cmd_q.push_back(cmd_byte);
    if (data_valid) data_q.push_back(data_byte);
    if (cmd_valid && data_valid) both_cnt++;
    if (sda_oe && !oe_d) ack_cnt++;
    oe_d = sda_oe;
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clr();
    cmd_q.delete();
    data_q.delete();
    ack_cnt  = 0;
    both_cnt = 0;
  endtask

  task automatic bus_start();
    wq(); sda_drv = 1'b1;
    wq(); scl = 1'b1;
    wq(); sda_drv = 1'b0;
    wq(); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wq(); sda_drv = 1'b0;
    wq(); scl = 1'b1;
    wq(); sda_drv = 1'b1;
    wq(); wq(); wq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      wq(); sda_drv = b[i];
      wq(); scl = 1'b1;
      wq(); wq(); scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
    wq(); sda_drv = 1'b1;
    wq(); scl = 1'b1;
    wq(); wq(); scl = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; sda_drv = 1'b1;
    repeat (3) @(negedge clk);
    vecs++;
    if ({sda_oe, cmd_valid, cmd_byte, data_valid, data_byte, busy, data_count, err} !== '0) begin
      errs++; $display("FAIL reset_outputs: got oe=%b busy=%b err=%b cnt=%0d, want all 0",
                       sda_oe, busy, err, data_count);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_commands();
    clr();
    bus_start();
    send_byte(8'h78); send_byte(8'h00);
    send_byte(8'hAE); send_byte(8'hA8); send_byte(8'h1F);
    vecs++;
    if (busy !== 1'b1) begin errs++; $display("FAIL cmd_busy_high: got %b want 1", busy); end
    bus_stop();
    vecs++;
    if (ack_cnt !== 5) begin errs++; $display("FAIL cmd_acks: got %0d want 5", ack_cnt); end
    vecs++;
    if (cmd_q.size() !== 3 || cmd_q[0] !== 8'hAE || cmd_q[1] !== 8'hA8 || cmd_q[2] !== 8'h1F) begin
      errs++; $display("FAIL cmd_bytes: got n=%0d %h %h %h want 3 ae a8 1f",
                       cmd_q.size(), cmd_q[0], cmd_q[1], cmd_q[2]);
    end
    vecs++;
    if (data_q.size() !== 0) begin errs++; $display("FAIL cmd_no_data: got %0d want 0", data_q.size()); end
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL cmd_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_data_stream();
    int bad;
    clr();
    bus_start();
    send_byte(8'h78); send_byte(8'h40);
    for (int i = 0; i < 300; i++) send_byte(8'hFF);
    vecs++;
    if (data_count !== 9'd300) begin errs++; $display("FAIL data_count_mid: got %0d want 300", data_count); end
    for (int i = 300; i < 512; i++) send_byte(8'hFF);
    bus_stop();
    bad = 0;
    foreach (data_q[i]) if (data_q[i] !== 8'hFF) bad++;
    vecs++;
    if (data_q.size() !== 512 || bad !== 0) begin
      errs++; $display("FAIL data_strobes: got n=%0d bad=%0d want 512 bad=0", data_q.size(), bad);
    end
    vecs++;
    if (data_count !== '0) begin errs++; $display("FAIL data_count_wrap: got %0d want 0", data_count); end
    vecs++;
    if (cmd_q.size() !== 0 || both_cnt !== 0) begin
      errs++; $display("FAIL data_no_cmd: got cmd=%0d both=%0d want 0 0", cmd_q.size(), both_cnt);
    end
    vecs++;
    if (err !== 1'b0) begin errs++; $display("FAIL data_no_err: got %b want 0", err); end
  endtask

  task automatic test_co_mixed();
    clr();
    bus_start();
    send_byte(8'h78); send_byte(8'h80); send_byte(8'hAF);
    send_byte(8'h40); send_byte(8'h12);
    bus_stop();
    vecs++;
    if (cmd_q.size() !== 1 || cmd_q[0] !== 8'hAF) begin
      errs++; $display("FAIL co_cmd: got n=%0d %h want 1 af", cmd_q.size(), cmd_q[0]);
    end
    vecs++;
    if (data_q.size() !== 1 || data_q[0] !== 8'h12) begin
      errs++; $display("FAIL co_data: got n=%0d %h want 1 12", data_q.size(), data_q[0]);
    end
    vecs++;
    if (data_count !== 9'd1) begin errs++; $display("FAIL co_count: got %0d want 1", data_count); end
    vecs++;
    if (ack_cnt !== 5) begin errs++; $display("FAIL co_acks: got %0d want 5", ack_cnt); end
  endtask

  task automatic test_wrong_addr();
    clr();
    bus_start();
    send_byte(8'h7A); send_byte(8'h00);
    vecs++;
    if (ack_cnt !== 0 || cmd_q.size() !== 0 || data_q.size() !== 0 || err !== 1'b0) begin
      errs++; $display("FAIL wrong_addr: got ack=%0d cmd=%0d data=%0d err=%b want 0 0 0 0",
                       ack_cnt, cmd_q.size(), data_q.size(), err);
    end
    bus_start();
    send_byte(8'h79);
    vecs++;
    if (ack_cnt !== 0 || err !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL read_req: got ack=%0d err=%b busy=%b want 0 1 0", ack_cnt, err, busy);
    end
    bus_start();
    repeat (6) @(negedge clk);
    vecs++;
    if (err !== 1'b0) begin errs++; $display("FAIL err_clear_on_start: got %b want 0", err); end
    bus_stop();
  endtask

  task automatic test_abort();
    clr();
    bus_start();
    send_byte(8'h78); send_byte(8'h40);
    send_bits(8'hA5, 4);
    bus_stop();
    vecs++;
    if (cmd_q.size() !== 0 || data_q.size() !== 0 || busy !== 1'b0) begin
      errs++; $display("FAIL abort: got cmd=%0d data=%0d busy=%b want 0 0 0",
                       cmd_q.size(), data_q.size(), busy);
    end
  endtask

  task automatic test_rep_start();
    clr();
    bus_start();
    send_byte(8'h78); send_byte(8'h00); send_byte(8'hAE);
    bus_start();
    send_byte(8'h78); send_byte(8'h40); send_byte(8'h55);
    bus_stop();
    vecs++;
    if (cmd_q.size() !== 1 || cmd_q[0] !== 8'hAE || data_q.size() !== 1 || data_q[0] !== 8'h55) begin
      errs++; $display("FAIL rep_start: got cmd n=%0d %h data n=%0d %h want 1 ae 1 55",
                       cmd_q.size(), cmd_q[0], data_q.size(), data_q[0]);
    end
    vecs++;
    if (data_count !== 9'd1) begin errs++; $display("FAIL rep_start_count: got %0d want 1", data_count); end
  endtask

  task automatic test_reset_mid_ack();
    int t;
    clr();
    bus_start();
    send_bits(8'h78, 8);
    sda_drv = 1'b1;
    t = 0;
    while (sda_oe !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    vecs++;
    if (sda_oe !== 1'b1) begin errs++; $display("FAIL mid_ack_timeout: got oe=%b want 1", sda_oe); end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({sda_oe, cmd_valid, cmd_byte, data_valid, data_byte, busy, data_count, err} !== '0) begin
      errs++; $display("FAIL reset_mid_ack: got oe=%b busy=%b err=%b want all 0", sda_oe, busy, err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    scl = 1'b1; sda_drv = 1'b1;
    repeat (6) @(negedge clk);
    clr();
    bus_start();
    send_byte(8'h78); send_byte(8'h00); send_byte(8'hAE);
    bus_stop();
    vecs++;
    if (cmd_q.size() !== 1 || cmd_q[0] !== 8'hAE || ack_cnt !== 3) begin
      errs++; $display("FAIL after_reset_frame: got cmd n=%0d %h acks=%0d want 1 ae 3",
                       cmd_q.size(), cmd_q[0], ack_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_commands();
    test_data_stream();
    test_co_mixed();
    test_wrong_addr();
    test_abort();
    test_rep_start();
    test_reset_mid_ack();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
